// File: rtl/mem_stack_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stack_stage
// Purpose  : Memory stage of the 5-stage 16-bit pipeline. Owns the data
//            memory and the stack pointer and executes LOAD, STORE, PUSH,
//            POP, CALL, RET and RTI. Multi-word stack operations hold the
//            upstream stages through 'stall'.
// Ports    : clk, rst               clock, asynchronous active-high reset
//            ex_*                   EX/MEM register contents
//            stall                  holds IF/ID/EX while a stack sequence runs
//            wb_valid/we/rd/data    registered MEM/WB result
//            pc_load/pc_value       one-cycle PC-restore request (RET, RTI)
//            ccr_load/ccr_value     one-cycle CCR-restore request (RTI)
//            sp                     current stack pointer
//            stack_err              sticky stack over/underflow flag
// Revision : 1.0  initial release
// ============================================================================
module mem_stack_stage #(
    parameter int AW      = 12,
    parameter int SP_INIT = (1 << AW) - 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ex_valid,
    input  logic [2:0]    ex_op,
    input  logic [AW-1:0] ex_addr,
    input  logic [15:0]   ex_wdata,
    input  logic [31:0]   ex_pc,
    input  logic [2:0]    ex_rd,
    input  logic          ex_rw,
    input  logic [15:0]   ex_alu,
    output logic          stall,
    output logic          wb_valid,
    output logic          wb_we,
    output logic [2:0]    wb_rd,
    output logic [15:0]   wb_data,
    output logic          pc_load,
    output logic [31:0]   pc_value,
    output logic          ccr_load,
    output logic [2:0]    ccr_value,
    output logic [AW-1:0] sp,
    output logic          stack_err
);

    localparam logic [2:0]    c_op_nop   = 3'b000;
    localparam logic [2:0]    c_op_load  = 3'b001;
    localparam logic [2:0]    c_op_store = 3'b010;
    localparam logic [2:0]    c_op_push  = 3'b011;
    localparam logic [2:0]    c_op_pop   = 3'b100;
    localparam logic [2:0]    c_op_call  = 3'b101;
    localparam logic [2:0]    c_op_ret   = 3'b110;
    localparam logic [2:0]    c_op_rti   = 3'b111;

    localparam logic [AW-1:0] c_sp_init  = AW'(SP_INIT);
    localparam logic [AW-1:0] c_sp_one   = AW'(1);
    localparam logic [AW-1:0] c_sp_max   = {AW{1'b1}};
    localparam logic [AW-1:0] c_sp_min   = {AW{1'b0}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CALL2 = 3'd1,
        S_RET2  = 3'd2,
        S_RTI2  = 3'd3,
        S_RTI3  = 3'd4
    } state_t;

    state_t          r_state;
    logic [AW-1:0]   r_sp;
    logic [15:0]     r_call_lo;   // low PC word still to be pushed by CALL
    logic [15:0]     r_ret_lo;    // low PC word popped first by RET/RTI
    logic [15:0]     r_ret_hi;    // high PC word, held while RTI pops the CCR
    logic [15:0]     r_mem [0:(1 << AW) - 1];

    logic [AW-1:0]   w_sp_inc;
    logic [AW-1:0]   w_sp_dec;
    logic [15:0]     w_load_data;
    logic [15:0]     w_pop_data;
    logic            w_push_wrap;
    logic            w_pop_wrap;
    logic            w_mem_we;
    logic [AW-1:0]   w_mem_addr;
    logic [15:0]     w_mem_wdata;

    assign w_sp_inc    = r_sp + c_sp_one;
    assign w_sp_dec    = r_sp - c_sp_one;
    assign w_load_data = r_mem[ex_addr];
    // Pop reads the word at SP+1, i.e. the slot SP will point at afterwards.
    assign w_pop_data  = r_mem[w_sp_inc];
    assign w_push_wrap = (r_sp == c_sp_min);
    assign w_pop_wrap  = (r_sp == c_sp_max);

    assign stall = (r_state != S_IDLE);
    assign sp    = r_sp;

    // Memory write port select. Gated by rst so no write lands while the
    // control state is being forced back to IDLE.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = r_sp;
        w_mem_wdata = ex_wdata;
        if (!rst) begin
            if (r_state == S_IDLE && ex_valid) begin
                case (ex_op)
                    c_op_store: begin
                        w_mem_we   = 1'b1;
                        w_mem_addr = ex_addr;
                    end
                    c_op_push: begin
                        w_mem_we   = 1'b1;
                    end
                    c_op_call: begin
                        w_mem_we    = 1'b1;
                        w_mem_wdata = ex_pc[31:16];
                    end
                    default: begin
                        w_mem_we = 1'b0;
                    end
                endcase
            end else if (r_state == S_CALL2) begin
                w_mem_we    = 1'b1;
                w_mem_wdata = r_call_lo;
            end
        end
    end

    // Data memory: synchronous write, combinational read, never reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_sp      <= c_sp_init;
            r_call_lo <= 16'h0000;
            r_ret_lo  <= 16'h0000;
            r_ret_hi  <= 16'h0000;
            wb_valid  <= 1'b0;
            wb_we     <= 1'b0;
            wb_rd     <= 3'd0;
            wb_data   <= 16'h0000;
            pc_load   <= 1'b0;
            pc_value  <= 32'h0000_0000;
            ccr_load  <= 1'b0;
            ccr_value <= 3'd0;
            stack_err <= 1'b0;
        end else begin
            // Pulses and the result-valid strobe last exactly one cycle.
            pc_load  <= 1'b0;
            ccr_load <= 1'b0;
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ex_valid) begin
                        case (ex_op)
                            c_op_nop: begin
                                wb_valid <= 1'b0;
                            end
                            c_op_load: begin
                                wb_valid <= 1'b1;
                                wb_we    <= ex_rw;
                                wb_rd    <= ex_rd;
                                wb_data  <= w_load_data;
                            end
                            c_op_store: begin
                                wb_valid <= 1'b1;
                                wb_we    <= 1'b0;
                                wb_rd    <= ex_rd;
                                wb_data  <= ex_alu;
                            end
                            c_op_push: begin
                                wb_valid <= 1'b1;
                                wb_we    <= ex_rw;
                                wb_rd    <= ex_rd;
                                wb_data  <= ex_alu;
                                r_sp     <= w_sp_dec;
                                if (w_push_wrap) stack_err <= 1'b1;
                            end
                            c_op_pop: begin
                                wb_valid <= 1'b1;
                                wb_we    <= ex_rw;
                                wb_rd    <= ex_rd;
                                wb_data  <= w_pop_data;
                                r_sp     <= w_sp_inc;
                                if (w_pop_wrap) stack_err <= 1'b1;
                            end
                            c_op_call: begin
                                r_call_lo <= ex_pc[15:0];
                                r_sp      <= w_sp_dec;
                                if (w_push_wrap) stack_err <= 1'b1;
                                r_state   <= S_CALL2;
                            end
                            c_op_ret: begin
                                r_ret_lo <= w_pop_data;
                                r_sp     <= w_sp_inc;
                                if (w_pop_wrap) stack_err <= 1'b1;
                                r_state  <= S_RET2;
                            end
                            c_op_rti: begin
                                r_ret_lo <= w_pop_data;
                                r_sp     <= w_sp_inc;
                                if (w_pop_wrap) stack_err <= 1'b1;
                                r_state  <= S_RTI2;
                            end
                            default: begin
                                wb_valid <= 1'b0;
                            end
                        endcase
                    end
                end
                S_CALL2: begin
                    r_sp    <= w_sp_dec;
                    if (w_push_wrap) stack_err <= 1'b1;
                    r_state <= S_IDLE;
                end
                S_RET2: begin
                    pc_value <= {w_pop_data, r_ret_lo};
                    pc_load  <= 1'b1;
                    r_sp     <= w_sp_inc;
                    if (w_pop_wrap) stack_err <= 1'b1;
                    r_state  <= S_IDLE;
                end
                S_RTI2: begin
                    // PC is not restored yet: it goes out together with the CCR.
                    r_ret_hi <= w_pop_data;
                    r_sp     <= w_sp_inc;
                    if (w_pop_wrap) stack_err <= 1'b1;
                    r_state  <= S_RTI3;
                end
                S_RTI3: begin
                    pc_value  <= {r_ret_hi, r_ret_lo};
                    pc_load   <= 1'b1;
                    ccr_value <= w_pop_data[2:0];
                    ccr_load  <= 1'b1;
                    r_sp      <= w_sp_inc;
                    if (w_pop_wrap) stack_err <= 1'b1;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stack_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stack_stage
// Purpose  : Self-checking bench for mem_stack_stage. A transaction-level
//            model turns each instruction into the list of per-cycle output
//            values it must produce; a compare process checks them cycle by
//            cycle, and literal checks pin the directed scenarios.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_stack_stage;

    localparam logic [2:0] c_nop = 3'd0, c_load = 3'd1, c_store = 3'd2,
                           c_push = 3'd3, c_pop = 3'd4, c_call = 3'd5,
                           c_ret = 3'd6, c_rti = 3'd7;

    logic        clk, rst;
    logic        ex_valid, ex_rw;
    logic [2:0]  ex_op, ex_rd;
    logic [11:0] ex_addr;
    logic [15:0] ex_wdata, ex_alu;
    logic [31:0] ex_pc;
    logic        stall, wb_valid, wb_we, pc_load, ccr_load, stack_err;
    logic [2:0]  wb_rd, ccr_value;
    logic [15:0] wb_data;
    logic [31:0] pc_value;
    logic [11:0] sp;

    mem_stack_stage dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_op(ex_op), .ex_addr(ex_addr),
        .ex_wdata(ex_wdata), .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_rw(ex_rw),
        .ex_alu(ex_alu),
        .stall(stall), .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd),
        .wb_data(wb_data), .pc_load(pc_load), .pc_value(pc_value),
        .ccr_load(ccr_load), .ccr_value(ccr_value), .sp(sp),
        .stack_err(stack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] m_mem [0:4095];
    logic [11:0] m_sp;
    logic        m_err;
    logic [31:0] m_pcv;
    logic [2:0]  m_ccv;

    typedef struct {
        logic        stall, wbv, we;
        logic [2:0]  rd;
        logic [15:0] data;
        logic        pcl;
        logic [31:0] pcv;
        logic        ccl;
        logic [2:0]  ccv;
        logic [11:0] sp;
        logic        err;
    } exp_t;

    exp_t exp_q[$];

    function automatic exp_t base();
        exp_t e;
        e.stall = 1'b0; e.wbv = 1'b0; e.we = 1'b0; e.rd = 3'd0; e.data = 16'h0;
        e.pcl = 1'b0; e.pcv = m_pcv; e.ccl = 1'b0; e.ccv = m_ccv;
        e.sp = m_sp; e.err = m_err;
        return e;
    endfunction

    task automatic m_push(input logic [15:0] d);
        if (m_sp == 12'h000) m_err = 1'b1;
        m_mem[m_sp] = d;
        m_sp = m_sp - 12'd1;
    endtask

    task automatic m_pop(output logic [15:0] d);
        if (m_sp == 12'hFFF) m_err = 1'b1;
        m_sp = m_sp + 12'd1;
        d = m_mem[m_sp];
    endtask

    task automatic m_reset();
        m_sp = 12'hFFF; m_err = 1'b0; m_pcv = 32'h0; m_ccv = 3'd0;
        exp_q.delete();
    endtask

    // ---------------- compare process ----------------
    exp_t ce;
    always @(posedge clk) begin
        #1;
        if (!rst && exp_q.size() > 0) begin
            ce = exp_q.pop_front();
            chk("stall",     32'(stall),     32'(ce.stall));
            chk("wb_valid",  32'(wb_valid),  32'(ce.wbv));
            if (ce.wbv) begin
                chk("wb_we", 32'(wb_we), 32'(ce.we));
                if (ce.we) begin
                    chk("wb_rd",   32'(wb_rd),   32'(ce.rd));
                    chk("wb_data", 32'(wb_data), 32'(ce.data));
                end
            end
            chk("pc_load",   32'(pc_load),   32'(ce.pcl));
            chk("pc_value",  pc_value,       ce.pcv);
            chk("ccr_load",  32'(ccr_load),  32'(ce.ccl));
            chk("ccr_value", 32'(ccr_value), 32'(ce.ccv));
            chk("sp",        32'(sp),        32'(ce.sp));
            chk("stack_err", 32'(stack_err), 32'(ce.err));
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input logic v, input logic [2:0] op, input logic [11:0] addr,
                         input logic [15:0] wd, input logic [31:0] pc,
                         input logic [2:0] rd, input logic rw, input logic [15:0] alu);
        exp_t e;
        logic [15:0] lo, hi, w;
        int k;
        @(negedge clk);
        ex_valid = v; ex_op = op; ex_addr = addr; ex_wdata = wd;
        ex_pc = pc; ex_rd = rd; ex_rw = rw; ex_alu = alu;
        k = 1;
        if (!v || op == c_nop) begin
            e = base(); exp_q.push_back(e);
        end else begin
            case (op)
                c_load: begin
                    e = base(); e.wbv = 1; e.we = rw; e.rd = rd; e.data = m_mem[addr];
                    exp_q.push_back(e);
                end
                c_store: begin
                    m_mem[addr] = wd;
                    e = base(); e.wbv = 1; e.we = 0; e.rd = rd;
                    exp_q.push_back(e);
                end
                c_push: begin
                    m_push(wd);
                    e = base(); e.wbv = 1; e.we = rw; e.rd = rd; e.data = alu;
                    exp_q.push_back(e);
                end
                c_pop: begin
                    m_pop(w);
                    e = base(); e.wbv = 1; e.we = rw; e.rd = rd; e.data = w;
                    exp_q.push_back(e);
                end
                c_call: begin
                    m_push(pc[31:16]);
                    e = base(); e.stall = 1; exp_q.push_back(e);
                    m_push(pc[15:0]);
                    e = base(); exp_q.push_back(e);
                    k = 2;
                end
                c_ret: begin
                    m_pop(lo);
                    e = base(); e.stall = 1; exp_q.push_back(e);
                    m_pop(hi);
                    m_pcv = {hi, lo};
                    e = base(); e.pcl = 1; exp_q.push_back(e);
                    k = 2;
                end
                default: begin // RTI
                    m_pop(lo);
                    e = base(); e.stall = 1; exp_q.push_back(e);
                    m_pop(hi);
                    e = base(); e.stall = 1; exp_q.push_back(e);
                    m_pop(w);
                    m_pcv = {hi, lo}; m_ccv = w[2:0];
                    e = base(); e.pcl = 1; e.ccl = 1; exp_q.push_back(e);
                    k = 3;
                end
            endcase
        end
        repeat (k) @(posedge clk);
        #2;
    endtask

    task automatic idle();
        issue(1'b0, c_nop, 12'h0, 16'h0, 32'h0, 3'd0, 1'b0, 16'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; ex_valid = 1'b0;
        #1;
        chk("rst_stall",    32'(stall),     32'h0);
        chk("rst_wb_valid", 32'(wb_valid),  32'h0);
        chk("rst_wb_we",    32'(wb_we),     32'h0);
        chk("rst_wb_data",  32'(wb_data),   32'h0);
        chk("rst_pc_load",  32'(pc_load),   32'h0);
        chk("rst_pc_value", pc_value,       32'h0);
        chk("rst_ccr_load", 32'(ccr_load),  32'h0);
        chk("rst_ccr_val",  32'(ccr_value), 32'h0);
        chk("rst_sp",       32'(sp),        32'hFFF);
        chk("rst_err",      32'(stack_err), 32'h0);
        @(negedge clk);
        m_reset();
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] lo;
        exp_t e;
        rst = 1'b1; ex_valid = 0; ex_op = 0; ex_addr = 0; ex_wdata = 0;
        ex_pc = 0; ex_rd = 0; ex_rw = 0; ex_alu = 0;
        m_reset();
        do_reset();

        // Give every memory word a known value.
        for (int a = 0; a < 4096; a++)
            issue(1, c_store, 12'(a), 16'($urandom), 32'h0, 3'd0, 1'b0, 16'h0);

        // STORE then LOAD.
        issue(1, c_store, 12'h010, 16'hBEEF, 32'h0, 3'd0, 1'b1, 16'h1111);
        issue(1, c_load,  12'h010, 16'h0, 32'h0, 3'd3, 1'b1, 16'h2222);
        chk("lit_load_valid", 32'(wb_valid), 32'h1);
        chk("lit_load_we",    32'(wb_we),    32'h1);
        chk("lit_load_rd",    32'(wb_rd),    32'h3);
        chk("lit_load_data",  32'(wb_data),  32'hBEEF);

        // PUSH then POP.
        issue(1, c_push, 12'h0, 16'h1234, 32'h0, 3'd0, 1'b0, 16'h0);
        chk("lit_push_sp", 32'(sp), 32'hFFE);
        issue(1, c_pop, 12'h0, 16'h0, 32'h0, 3'd5, 1'b1, 16'h0);
        chk("lit_pop_sp",   32'(sp),      32'hFFF);
        chk("lit_pop_data", 32'(wb_data), 32'h1234);
        issue(1, c_load, 12'hFFF, 16'h0, 32'h0, 3'd1, 1'b1, 16'h0);
        chk("lit_mem_fff", 32'(wb_data), 32'h1234);

        // CALL then RET.
        issue(1, c_call, 12'h0, 16'h0, 32'h0001_0ABC, 3'd0, 1'b0, 16'h0);
        chk("lit_call_sp", 32'(sp), 32'hFFD);
        issue(1, c_ret, 12'h0, 16'h0, 32'h0, 3'd0, 1'b0, 16'h0);
        chk("lit_ret_pcl", 32'(pc_load), 32'h1);
        chk("lit_ret_pcv", pc_value,     32'h0001_0ABC);
        chk("lit_ret_sp",  32'(sp),      32'hFFF);
        idle();
        issue(1, c_load, 12'hFFF, 16'h0, 32'h0, 3'd2, 1'b1, 16'h0);
        chk("lit_call_hi", 32'(wb_data), 32'h0001);
        issue(1, c_load, 12'hFFE, 16'h0, 32'h0, 3'd2, 1'b1, 16'h0);
        chk("lit_call_lo", 32'(wb_data), 32'h0ABC);

        // RTI from a prepared frame.
        do_reset();
        issue(1, c_push, 12'h0, 16'h0005, 32'h0, 3'd0, 1'b0, 16'h0);
        issue(1, c_push, 12'h0, 16'h0000, 32'h0, 3'd0, 1'b0, 16'h0);
        issue(1, c_push, 12'h0, 16'h0020, 32'h0, 3'd0, 1'b0, 16'h0);
        chk("lit_pre_sp", 32'(sp), 32'hFFC);
        issue(1, c_rti, 12'h0, 16'h0, 32'h0, 3'd0, 1'b0, 16'h0);
        chk("lit_rti_pcl", 32'(pc_load),   32'h1);
        chk("lit_rti_ccl", 32'(ccr_load),  32'h1);
        chk("lit_rti_pcv", pc_value,       32'h0000_0020);
        chk("lit_rti_ccv", 32'(ccr_value), 32'h5);
        chk("lit_rti_sp",  32'(sp),        32'hFFF);
        idle();

        // Pop underflow wraps and sets the sticky error.
        issue(1, c_pop, 12'h0, 16'h0, 32'h0, 3'd4, 1'b1, 16'h0);
        chk("lit_wrap_sp",  32'(sp),        32'h000);
        chk("lit_wrap_err", 32'(stack_err), 32'h1);
        issue(1, c_push, 12'h0, 16'h7777, 32'h0, 3'd0, 1'b0, 16'h0);
        issue(1, c_load, 12'h010, 16'h0, 32'h0, 3'd1, 1'b1, 16'h0);
        chk("lit_err_sticky", 32'(stack_err), 32'h1);

        // Reset in the middle of RET.
        do_reset();
        @(negedge clk);
        ex_valid = 1; ex_op = c_ret; ex_rw = 0;
        m_pop(lo);
        e = base(); e.stall = 1; exp_q.push_back(e);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_stall", 32'(stall),   32'h0);
        chk("midrst_pcl",   32'(pc_load), 32'h0);
        chk("midrst_sp",    32'(sp),      32'hFFF);
        @(negedge clk);
        ex_valid = 0;
        m_reset();
        @(negedge clk);
        rst = 1'b0;
        issue(1, c_load, 12'h010, 16'h0, 32'h0, 3'd6, 1'b1, 16'h0);
        chk("lit_post_rst_load", 32'(wb_data), 32'hBEEF);
        idle();
        chk("lit_post_rst_pcl", 32'(pc_load), 32'h0);

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 400; i++)
            issue(($urandom_range(0, 9) != 0), 3'($urandom_range(0, 7)),
                  12'($urandom), 16'($urandom), $urandom, 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 16'($urandom));
        repeat (3) idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_stack_stage.md
Name: mem_stack_stage

Overview:
- Memory stage of the 5-stage 16-bit pipeline. It sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- It owns the data memory and the stack pointer (SP), and executes load, store, push, pop, CALL, RET and RTI.
- It produces registered write-back results, PC-restore requests and CCR-restore requests.
- Multi-word stack operations stall upstream stages through the stall output.

Parameters:
- AW, 12, data-memory address width in 16-bit words; the memory holds 2^AW words.
- SP_INIT, 2^AW-1, SP value after reset.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- ex_valid  in  1  EX/MEM register holds a valid instruction.
- ex_op  in  3  operation code: 000 NOP, 001 LOAD, 010 STORE, 011 PUSH, 100 POP, 101 CALL, 110 RET, 111 RTI.
- ex_addr  in  AW  effective address for LOAD/STORE (the ALU result).
- ex_wdata  in  16  store/push data.
- ex_pc  in  32  return address pushed by CALL.
- ex_rd  in  3  destination register.
- ex_rw  in  1  register-write enable.
- ex_alu  in  16  ALU result, passed through for non-load instructions.
- stall  out  1  holds IF/ID/EX; the EX/MEM inputs are held stable while this is 1.
- wb_valid  out  1  MEM/WB result valid.
- wb_we  out  1  register-write enable to write-back.
- wb_rd  out  3  destination register to write-back.
- wb_data  out  16  loaded data or passed-through ALU result.
- pc_load  out  1  one-cycle pulse: fetch loads pc_value.
- pc_value  out  32  restored PC.
- ccr_load  out  1  one-cycle pulse: CCR loads ccr_value.
- ccr_value  out  3  restored flags.
- sp  out  AW  current SP.
- stack_err  out  1  sticky stack over/underflow flag.

Behaviour:
- Reset (asynchronous, active-high, any time including mid-sequence):
  - State goes to IDLE and SP becomes SP_INIT.
  - Every output becomes 0, except sp = SP_INIT.
  - Memory contents are not cleared.
- Memory: synchronous write on the rising edge; combinational read.
- SP arithmetic is modulo 2^AW:
  - Push: mem[SP] is written, then SP decrements by 1.
  - Pop: SP increments by 1, then mem[SP] is read.
- Accept: an instruction is accepted on a rising edge when state = IDLE and ex_valid = 1. ex_valid = 0 is treated as NOP.
- stall = (state != IDLE). It is combinational from the state register only, never from the inputs.
- Single-cycle ops, accepted at edge N; MEM/WB outputs are registered and valid after edge N:
  - NOP: wb_valid = 0.
  - LOAD: wb_data = mem[ex_addr].
  - STORE: mem[ex_addr] = ex_wdata, wb_we = 0.
  - PUSH: mem[SP] = ex_wdata, SP = SP-1.
  - POP: SP = SP+1, wb_data = mem[SP+1].
  - Others with ex_rw = 1: wb_data = ex_alu.
  - wb_we = ex_rw and wb_rd = ex_rd for all of the above except STORE.
- State machine states: IDLE, CALL2, RET2, RTI2, RTI3.
- CALL:
  - Edge N: mem[SP] = ex_pc[31:16], SP-1, state goes to CALL2.
  - Edge N+1: mem[SP] = ex_pc[15:0], SP-1, state goes to IDLE.
  - CALL does not drive pc_load; fetch takes the branch target from decode.
- RET:
  - Edge N: pop the low word into an internal latch, state goes to RET2.
  - Edge N+1: pop the high word; pc_value = {high, low}; pc_load pulses for the cycle after edge N+1; state goes to IDLE.
- RTI:
  - Edges N and N+1: same as RET (PC low, then PC high).
  - Edge N+2: pop the CCR word; ccr_value = word[2:0]; ccr_load pulses.
  - pc_load and ccr_load pulse together after edge N+2. pc_load is not asserted after edge N+1 for RTI.
- wb_valid is 0 during CALL/RET/RTI; those ops write no register.
- pc_load and ccr_load are single-cycle pulses.
- stack_err:
  - Set when a push occurs with SP = 0, or a pop occurs with SP = 2^AW-1.
  - The operation still completes with wrap-around.
  - Cleared only by reset.
- Inputs presented while stall = 1 are ignored. Upstream holds the EX/MEM register, so ex_* is stable. ex_pc is latched at accept.

Test Plan:
- Reset, then STORE addr 0x010 data 0xBEEF, then LOAD addr 0x010 rd 3 -> after the LOAD edge: wb_valid = 1, wb_we = 1, wb_rd = 3, wb_data = 0xBEEF; stall stays 0.
- PUSH 0x1234 then POP rd 5 from reset -> sp goes 0xFFF→0xFFE→0xFFF; wb_data = 0x1234; mem[0xFFF] = 0x1234.
- CALL ex_pc = 0x0001_0ABC, then RET -> mem[0xFFF] = 0x0001, mem[0xFFE] = 0x0ABC; stall high one cycle each; pc_load one-cycle pulse with pc_value = 0x00010ABC; sp back to 0xFFF.
- Preload mem[0xFFD..0xFFF] = 0x0020 / 0x0000 / 0x0005, sp = 0xFFC, RTI -> stall high for 2 cycles; pc_value = 0x00000020, ccr_value = 3'b101; pc_load and ccr_load pulse together once; sp = 0xFFF.
- POP at sp = 0xFFF -> sp wraps to 0x000, stack_err = 1 and stays 1 through later ops until rst.
- Assert rst during RET2 -> immediately stall = 0, pc_load = 0, sp = 0xFFF; a following LOAD behaves normally.
